// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared constants for the fifo_wr_arb write arbiter.
// Holds the FIFO status encodings and the level-counter width helper.
package fifo_arb_pkg;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b11;

    // Bits needed to hold 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: req[N] requests, ptr last winner; gnt one-hot winner, idx encoded winner, any = some req set.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Scan ptr+1, ptr+2, ... wrapping at N; the first set request wins.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter and credit tracker for one FIFO write port.
// Ports: clk, rst_n (async low); req[N]/din[N*W] in, gnt[N] out (comb); cke/data registered
// FIFO write; rd_cke FIFO read mirror; status FIFO status; level/full/empty occupancy; err sticky.
// Option macro FIFO_ARB_STATUS_CHK_EN: gate accepts on status full and cross-check status vs level.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DEPTH = 512,
    parameter int LW    = level_w(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  din,
    output logic [N-1:0]    gnt,
    output logic            cke,
    output logic [W-1:0]    data,
    input  logic            rd_cke,
    input  logic [1:0]      status,
    output logic [LW-1:0]   level,
    output logic            full,
    output logic            empty,
    output logic            err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          cke_q, cke_d;
    logic [W-1:0]  data_q, data_d;
    logic [LW-1:0] level_q, level_d;
    logic          err_q, err_d;

    logic [N-1:0]  pick_gnt;
    logic [PW-1:0] pick_idx;
    logic          pick_any;

    logic room, gate, acc, rd_eff, underflow, st_err;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Level counts words at accept time, so it leads the FIFO by a cycle.
    assign room = (level_q < LW'(DEPTH));

`ifdef FIFO_ARB_STATUS_CHK_EN
    // One word of slack on each side absorbs the FIFO status register lag.
    assign gate   = (status != ST_FULL);
    assign st_err = ((status == ST_FULL) && (level_q <= LW'(DEPTH - 2)))
                 || ((status == ST_EMPTY) && (level_q >= LW'(2)));
`else
    logic unused_status;
    assign unused_status = ^status;
    assign gate   = 1'b1;
    assign st_err = 1'b0;
`endif

    assign acc       = pick_any & room & gate;
    assign gnt       = acc ? pick_gnt : '0;
    assign rd_eff    = rd_cke & (level_q != '0);
    assign underflow = rd_cke & (level_q == '0);

    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        cke_d   = acc;
        if (acc) begin
            ptr_d  = pick_idx;
            data_d = din[int'(pick_idx)*W +: W];
        end
        level_d = level_q + LW'(acc) - LW'(rd_eff);
        err_d   = err_q | underflow | st_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= PW'(N - 1);
            cke_q   <= 1'b0;
            data_q  <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cke_q   <= cke_d;
            data_q  <= data_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    assign cke   = cke_q;
    assign data  = data_q;
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign err   = err_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed self-checking bench for fifo_wr_arb (N=4, W=8, DEPTH=512).
// One task per scenario; each task checks its own expectations inline.
module tb_fifo_wr_arb;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 512;
    localparam int LW    = $clog2(DEPTH + 1);

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*W-1:0]  din;
    logic [N-1:0]    gnt;
    logic            cke;
    logic [W-1:0]    data;
    logic            rd_cke;
    logic [1:0]      status;
    logic [LW-1:0]   level;
    logic            full;
    logic            empty;
    logic            err;

    int tests;
    int fails;

    fifo_wr_arb #(
        .N     (N),
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .din    (din),
        .gnt    (gnt),
        .cke    (cke),
        .data   (data),
        .rd_cke (rd_cke),
        .status (status),
        .level  (level),
        .full   (full),
        .empty  (empty),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req    = '0;
        din    = '0;
        rd_cke = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        req    = '0;
        din    = '0;
        rd_cke = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (cke !== 1'b0) begin
            fails++;
            $display("FAIL reset_cke got %b want 0", cke);
        end
        tests++;
        if (data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data got %h want 00", data);
        end
        tests++;
        if (level !== '0) begin
            fails++;
            $display("FAIL reset_level got %0d want 0", level);
        end
        tests++;
        if (empty !== 1'b1 || full !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got e%b f%b err%b want e1 f0 err0",
                     empty, full, err);
        end
        tests++;
        if (gnt !== 4'b0000) begin
            fails++;
            $display("FAIL reset_gnt got %b want 0000", gnt);
        end
        rst_n = 1'b1;
        req   = 4'b0001;
        din[0*W +: W] = 8'h5A;
        #1;
        tests++;
        if (gnt !== 4'b0001) begin
            fails++;
            $display("FAIL release_gnt got %b want 0001", gnt);
        end
        step();
        req = '0;
        #1;
        tests++;
        if (cke !== 1'b1 || data !== 8'h5A) begin
            fails++;
            $display("FAIL release_write got cke%b %h want cke1 5a", cke, data);
        end
        tests++;
        if (level !== LW'(1)) begin
            fails++;
            $display("FAIL release_level got %0d want 1", level);
        end
        step();
        tests++;
        if (cke !== 1'b0 || data !== 8'h5A) begin
            fails++;
            $display("FAIL idle_hold got cke%b %h want cke0 5a", cke, data);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        logic [W-1:0] ed;
        do_reset();
        for (int i = 0; i < N; i++) din[i*W +: W] = 8'hA0 + 8'(i);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            eg = 4'b0001 << (k % 4);
            ed = 8'hA0 + 8'(k % 4);
            tests++;
            if (gnt !== eg) begin
                fails++;
                $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, eg);
            end
            step();
            tests++;
            if (cke !== 1'b1 || data !== ed) begin
                fails++;
                $display("FAIL rr_data[%0d] got cke%b %h want cke1 %h",
                         k, cke, data, ed);
            end
        end
        req = '0;
        #1;
        tests++;
        if (level !== LW'(8)) begin
            fails++;
            $display("FAIL rr_level got %0d want 8", level);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            req = 4'b0100;
            din[2*W +: W] = 8'(k);
            #1;
            tests++;
            if (gnt !== 4'b0100) begin
                fails++;
                $display("FAIL stream_gnt[%0d] got %b want 0100", k, gnt);
            end
            step();
            tests++;
            if (cke !== 1'b1 || data !== 8'(k)) begin
                fails++;
                $display("FAIL stream_data[%0d] got cke%b %h want cke1 %h",
                         k, cke, data, 8'(k));
            end
        end
        req = '0;
        step();
        tests++;
        if (cke !== 1'b0 || level !== LW'(10)) begin
            fails++;
            $display("FAIL stream_end got cke%b lvl%0d want cke0 lvl10",
                     cke, level);
        end
    endtask

    task automatic test_full();
        int ng;
        do_reset();
        ng = 0;
        req = 4'b0001;
        din[0*W +: W] = 8'h33;
        for (int k = 0; k < 530; k++) begin
            #1;
            if (gnt[0] === 1'b1) ng++;
            step();
        end
        #1;
        tests++;
        if (ng != DEPTH) begin
            fails++;
            $display("FAIL full_grants got %0d want %0d", ng, DEPTH);
        end
        tests++;
        if (full !== 1'b1 || level !== LW'(DEPTH)) begin
            fails++;
            $display("FAIL full_flag got f%b lvl%0d want f1 lvl512", full, level);
        end
        tests++;
        if (gnt !== 4'b0000) begin
            fails++;
            $display("FAIL full_gnt got %b want 0000", gnt);
        end
        rd_cke = 1'b1;
        #1;
        tests++;
        if (gnt !== 4'b0000) begin
            fails++;
            $display("FAIL full_rd_gnt got %b want 0000", gnt);
        end
        step();
        rd_cke = 1'b0;
        #1;
        tests++;
        if (level !== LW'(DEPTH - 1)) begin
            fails++;
            $display("FAIL full_rd_level got %0d want 511", level);
        end
        ng = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (gnt[0] === 1'b1) ng++;
            step();
        end
        tests++;
        if (ng != 1 || level !== LW'(DEPTH)) begin
            fails++;
            $display("FAIL full_resume got %0d grants lvl%0d want 1 lvl512",
                     ng, level);
        end
        req = '0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 4'b0001;
        din[0*W +: W] = 8'h11;
        repeat (5) step();
        tests++;
        if (level !== LW'(5)) begin
            fails++;
            $display("FAIL sim_pre_level got %0d want 5", level);
        end
        rd_cke = 1'b1;
        #1;
        tests++;
        if (gnt !== 4'b0001) begin
            fails++;
            $display("FAIL sim_gnt got %b want 0001", gnt);
        end
        step();
        req = '0;
        #1;
        tests++;
        if (level !== LW'(5)) begin
            fails++;
            $display("FAIL sim_level got %0d want 5", level);
        end
        repeat (5) step();
        tests++;
        if (level !== '0 || empty !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL drain got lvl%0d e%b err%b want lvl0 e1 err0",
                     level, empty, err);
        end
        step();
        rd_cke = 1'b0;
        #1;
        tests++;
        if (level !== '0 || err !== 1'b1) begin
            fails++;
            $display("FAIL underflow got lvl%0d err%b want lvl0 err1", level, err);
        end
        repeat (4) step();
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky got %b want 1", err);
        end
        do_reset();
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear got %b want 0", err);
        end
    endtask

`ifdef FIFO_ARB_STATUS_CHK_EN
    task automatic test_status();
        do_reset();
        req = 4'b0001;
        din[0*W +: W] = 8'h77;
        repeat (3) step();
        status = 2'b11;
        #1;
        tests++;
        if (gnt !== 4'b0000) begin
            fails++;
            $display("FAIL st_gnt got %b want 0000", gnt);
        end
        repeat (2) step();
        tests++;
        if (level !== LW'(3) || err !== 1'b1) begin
            fails++;
            $display("FAIL st_block got lvl%0d err%b want lvl3 err1", level, err);
        end
        req    = '0;
        status = 2'b01;
    endtask
`endif

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        req    = '0;
        din    = '0;
        rd_cke = 1'b0;
        status = 2'b01;
        test_reset();
        test_round_robin();
        test_stream();
        test_full();
        test_simultaneous();
`ifdef FIFO_ARB_STATUS_CHK_EN
        test_status();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin write arbiter and credit tracker in front of one fifo_8 instance.
- Shares the FIFO's single write port (cke/data) between N producers.
- Grants at most one word per clock.
- Tracks FIFO occupancy from its own write acceptances and the consumer's read strobe, so it never writes into a full FIFO despite status latency.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, data word width; must match the FIFO data width.
- DEPTH, 512, FIFO capacity in words.
- LW, $clog2(DEPTH+1), width of the level counter.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N  req[i]=1: requester i has a word on its slice of din.
- din  in  N*W  requester words; slice i is din[i*W +: W].
- gnt  out  N  one-hot, combinational; word i accepted at the coming edge.
- cke  out  1  registered write strobe to FIFO cke.
- data  out  W  registered write data to FIFO data.
- rd_cke  in  1  mirror of FIFO cke_o (one word read per high cycle).
- status  in  2  FIFO status; 2'b00 empty, 2'b11 full. Used only under the option.
- level  out  LW  tracked occupancy 0..DEPTH.
- full  out  1  level==DEPTH.
- empty  out  1  level==0.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): cke=0, data=0, level=0, err=0, ptr=N-1. gnt is 0 because level<DEPTH is not a grant condition by itself; gnt needs a req.
- Accept condition: any req set AND level<DEPTH (and the option gate, when enabled).
- Winner selection: first set req[i] scanning ptr+1, ptr+2, ... modulo N.
  - gnt[winner]=1 in the same cycle; all other gnt bits are 0.
  - No accept → gnt=0.
- Handshake: a word transfers on the posedge where req[i]&gnt[i].
  - Requester holds req and din stable until granted.
  - It may present the next word in the following cycle.
  - A single requester can therefore stream one word per clock.
- On accept edge:
  - data<=din[winner], cke<=1, ptr<=winner.
  - Otherwise cke<=0, data holds its value, ptr holds its value.
- Latency: FIFO sees cke/data one cycle after the grant cycle.
- Level update: level += acc - rd_eff, where rd_eff = rd_cke & (level!=0).
  - Accept and read in the same cycle → level unchanged.
  - Level counts at accept time, i.e. conservatively one cycle ahead of the FIFO.
- Full boundary: at level==DEPTH no grant, even if rd_cke=1 in the same cycle. The grant resumes the next cycle.
- Underflow: rd_cke=1 while level==0 → level stays 0, err<=1.
- Fairness: with all N requesting continuously, grants rotate 0,1,..,N-1,0,...; no requester waits more than N-1 grants.
- Reset mid-transfer: cke drops immediately (async); words already written are not recounted. The FIFO must be reset together with this block.

Optional Feature:
- Macro FIFO_ARB_STATUS_CHK_EN.
- Defined:
  - Accept is additionally blocked while status==2'b11.
  - err<=1 if status==2'b11 while level<=DEPTH-2.
  - err<=1 if status==2'b00 while level>=2.
  - The 1-word margin covers the status register lag.
- Undefined: status is ignored (port kept, unconnected internally); err comes from underflow only.

Decomposition:
- Package fifo_arb_pkg holds:
  - status encodings ST_EMPTY=2'b00, ST_FULL=2'b11;
  - the level-width helper function.
- One sub-module, rr_pick: combinational picker taking req[N] and ptr, returning one-hot grant and encoded winner index.
- Level counter and output registers stay in the top module.

Test Plan:
- Reset: rst_n=0 for 3 cycles → cke=0, data=0, level=0, empty=1, gnt=0. Release with req=4'b0001 → gnt=4'b0001 the same cycle, cke=1 next cycle.
- Round-robin: req=4'b1111 held 8 cycles, din slice i = 8'hA0+i → FIFO data sequence A0,A1,A2,A3,A0,A1,A2,A3; level=8.
- Single streamer: requester 2 presents 0..9 on consecutive cycles → 10 back-to-back cke pulses, data 0..9 in order, no gaps.
- Full: DEPTH=512, 530 words offered from requester 0, rd_cke=0 → exactly 512 grants; full=1; gnt=0 thereafter. One rd_cke pulse → exactly one more grant, level returns to 512.
- Simultaneous: level=5, accept and rd_cke in the same cycle → level stays 5. rd_cke with level=0 → level 0, err=1, and err remains 1 until reset.
- With FIFO_ARB_STATUS_CHK_EN: force status=2'b11 at level=3 → no grant while forced, err=1.
